// File: rtl/mem_port_arbiter.sv
// Shares one cache-line memory port among NUM_REQ requesters; one grant per transaction, held until rvalid.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; round-robin otherwise.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH_CACHE
`define DATA_WIDTH_CACHE 128
`endif

module mem_port_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = `ADDR_WIDTH,
    parameter int unsigned DATA_W  = `DATA_WIDTH_CACHE
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_cs_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [DATA_W-1:0]         req_rdata_o,
    output logic [NUM_REQ-1:0]        req_rvalid_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    output logic                      mem_we_o,
    output logic                      mem_cs_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    input  logic                      mem_rvalid_i
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               cs_q, cs_d;
    logic               busy_q, busy_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    int unsigned        cand;

    // Winner selection: first requester at or after last_q+1 (wrapping), or lowest index in fixed mode.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            cand = i;
`else
            cand = (32'(last_q) + i + 32'd1) % NUM_REQ;
`endif
            if (!win_found && req_cs_i[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // Next state, latched command and completion routing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        cs_d         = cs_q;
        busy_d       = busy_q;
        req_rvalid_o = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    owner_d = win_idx;
                    grant_d = NUM_REQ'(1) << win_idx;
                    addr_d  = req_addr_i[32'(win_idx)*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata_i[32'(win_idx)*DATA_W +: DATA_W];
                    we_d    = req_we_i[win_idx];
                    cs_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            BUSY: begin
                if (mem_rvalid_i) begin
                    // Completion is passed through in the same cycle; a reset in flight suppresses it.
                    req_rvalid_o = rst_ni ? grant_q : '0;
                    last_d       = owner_q;
                    state_d      = IDLE;
                    grant_d      = '0;
                    cs_d         = 1'b0;
                    busy_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = we_q;
    assign mem_cs_o    = cs_q;
    assign req_rdata_o = mem_rdata_i;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the single cache-line memory port of the AXI master interface among `NUM_REQ` requesters, e.g. the CPU cache and a second on-chip client. It sits between the requesters and the AXI master interface's `addr_i/wdata_i/we_i/cs_i/rdata_o/rvalid_o` port. It grants one requester at a time and latches that requester's command. The grant is held until the memory port returns `rvalid`, then the completion is routed back to the owner.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `ADDR_W`, `` `ADDR_WIDTH ``: address width.
- `DATA_W`, `` `DATA_WIDTH_CACHE ``: line data width.

- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `req_cs_i` in NUM_REQ: request valid per requester. Must be held with its command until its `req_rvalid_o`.
- `req_we_i` in NUM_REQ: 1 = write, 0 = read.
- `req_addr_i` in NUM_REQ*ADDR_W: flattened; requester k occupies bits [k*ADDR_W +: ADDR_W].
- `req_wdata_i` in NUM_REQ*DATA_W: flattened, same packing.
- `req_rdata_o` out DATA_W: broadcast of `mem_rdata_i`.
- `req_rvalid_o` out NUM_REQ: one-hot completion pulse to the owner.
- `grant_o` out NUM_REQ: one-hot current owner; 0 when idle.
- `busy_o` out 1: a transaction is outstanding.
- `mem_addr_o` out ADDR_W: address to the memory port.
- `mem_wdata_o` out DATA_W: write data to the memory port.
- `mem_we_o` out 1: write enable to the memory port.
- `mem_cs_o` out 1: chip select to the memory port.
- `mem_rdata_i` in DATA_W: read data from the memory port.
- `mem_rvalid_i` in 1: completion pulse from the memory port, for both reads and writes.

## Operation
- FSM states: IDLE, BUSY.
- **IDLE**
  - If any `req_cs_i` bit is set, select a winner g, then:
    - latch g's addr/we/wdata into output registers;
    - set `grant_o`=1<<g;
    - move to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - `mem_cs_o`=1; addr/we/wdata are driven from the latched registers and stay stable.
  - When `mem_rvalid_i`=1:
    - `req_rvalid_o[g]`=1 in the same cycle (combinational);
    - `req_rdata_o`=`mem_rdata_i`;
    - `last_q`←g;
    - next state is IDLE, with `mem_cs_o`=0 and `grant_o`=0.
- **Round-robin selection:** search for the first set `req_cs_i` bit starting at index (`last_q`+1) mod NUM_REQ, wrapping. `last_q` resets to NUM_REQ-1, so requester 0 wins first after reset.
- **Requester drops `req_cs_i` while BUSY:** ignored. The transaction completes and the rvalid pulse is still delivered.
- **Requester keeps `req_cs_i` high after its rvalid:** treated as a new request, arbitrated fairly against the others in the following IDLE cycle.
- **`mem_rvalid_i` in IDLE:** ignored. No `req_rvalid_o` is raised.
- **Reset, including mid-transaction:**
  - state←IDLE, `last_q`←NUM_REQ-1;
  - `mem_cs_o`, `mem_we_o`, `grant_o`, `busy_o`, `req_rvalid_o` all 0;
  - `mem_addr_o` and `mem_wdata_o` are 0.
  - An outstanding transaction is abandoned.

## Timing
- All `mem_*_o`, `grant_o` and `busy_o` are registered.
- `req_rvalid_o` and `req_rdata_o` are combinational from `mem_rvalid_i`/`mem_rdata_i`.
- Grant latency: `req_cs_i` sampled high in IDLE at edge N gives `mem_cs_o`=1 after edge N.
- `mem_cs_o` falls in the cycle after `mem_rvalid_i`.
- Every transaction is followed by at least one IDLE cycle with `mem_cs_o`=0, so the memory port never sees back-to-back `cs` without a gap.
- Throughput: one transaction per (memory latency + 1) cycles.
- `busy_o` == (state==BUSY).

## Configuration
- **`ARB_FIXED_PRIO_EN` defined:** fixed priority; the lowest set index always wins. `last_q` is still updated but does not affect selection.
- **`ARB_FIXED_PRIO_EN` undefined (default):** round-robin as described under Operation.

## Test plan
- Reset, then req0 issues a read to 0x100 with the memory returning rvalid 3 cycles later:
  - `mem_cs_o` is high 1 cycle after the request;
  - `mem_addr_o`=0x100, `mem_we_o`=0;
  - `req_rvalid_o`=2'b01 with the correct data.
- req0 and req1 both held high for 4 transactions: grants alternate 0,1,0,1, and `mem_cs_o` is low for exactly 1 cycle between transactions.
- Same stimulus with `ARB_FIXED_PRIO_EN`: grants are 0,0,0,0 while req0 is held, and req1 is served only after req0 drops.
- req1 write to 0x2C0 with data 0xA5…; `req_wdata_i[1]` is changed while BUSY: `mem_wdata_o` keeps the original value until rvalid.
- `rst_ni` low for 1 cycle while BUSY, then a spurious `mem_rvalid_i`: all outputs are 0, no `req_rvalid_o` pulse, and the next grant goes to req0.
- `mem_rvalid_i` pulsed while IDLE with no requests: no `req_rvalid_o`, and the state stays IDLE.
